// File: rtl/pe_operand_streamer.sv
// pe_operand_streamer: loads a dense activation window over a ready/valid
// stream, then replays the sparse kernel against it as one (activation,
// weight) pair per cycle into a processing_element. The PE accumulator is
// cleared before each window, and the PE result is captured after it drains.
// Optional feature macro: OPERAND_GATE_EN. When it is defined, the weight
// operand is forced to zero whenever the selected activation is zero.
module pe_operand_streamer #(
    parameter int NON_ZERO_WEIGHTS = 27,
    parameter int WINDOW_SIZE      = 27,
    parameter int IDX_BITS         = 5,
    parameter int BIT_SIZE         = 16,
    parameter int RESULT_LATENCY   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wt_wr_en,
    input  logic [IDX_BITS-1:0] wt_wr_addr,
    input  logic [BIT_SIZE-1:0] wt_wr_data,
    input  logic [IDX_BITS-1:0] wt_wr_idx,
    input  logic                win_valid,
    output logic                win_ready,
    input  logic [BIT_SIZE-1:0] win_data,
    output logic [BIT_SIZE-1:0] pe_activation,
    output logic [BIT_SIZE-1:0] pe_weight,
    output logic                pe_rst_n,
    input  logic [BIT_SIZE-1:0] pe_out,
    output logic                res_valid,
    output logic [BIT_SIZE-1:0] res_data
);

    localparam int DCNT_BITS = $clog2(RESULT_LATENCY + 1);
    localparam logic [IDX_BITS-1:0]  LAST_WORD  = IDX_BITS'(WINDOW_SIZE - 1);
    localparam logic [IDX_BITS-1:0]  LAST_SLOT  = IDX_BITS'(NON_ZERO_WEIGHTS - 1);
    localparam logic [DCNT_BITS-1:0] LAST_DRAIN = DCNT_BITS'(RESULT_LATENCY - 1);

    typedef enum logic [1:0] {LOAD, CLEAR, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [BIT_SIZE-1:0] data;
        logic [IDX_BITS-1:0] idx;
    } kernel_entry_t;

    kernel_entry_t       wmem   [NON_ZERO_WEIGHTS];
    logic [BIT_SIZE-1:0] window [WINDOW_SIZE];

    state_t               state, state_next;
    logic [IDX_BITS-1:0]  wcnt, wcnt_next;
    logic [IDX_BITS-1:0]  scnt, scnt_next;
    logic [DCNT_BITS-1:0] dcnt, dcnt_next;

    logic [IDX_BITS-1:0] sel;
    logic [IDX_BITS-1:0] pair_idx;
    logic [BIT_SIZE-1:0] pair_act;
    logic [BIT_SIZE-1:0] pair_wt;

    logic [BIT_SIZE-1:0] act_next;
    logic [BIT_SIZE-1:0] wt_next;
    logic                pe_rst_n_next;
    logic                win_ready_next;
    logic                res_valid_next;
    logic                capture;
    logic                win_accept;

    assign win_accept = (state == LOAD) && win_ready && win_valid;

    // Kernel memory: writes accepted in any state, visible from the next clock.
    // NOTE: storage arrays carry no reset; their contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (wt_wr_en && (int'(wt_wr_addr) < NON_ZERO_WEIGHTS)) begin
            wmem[wt_wr_addr] <= '{data: wt_wr_data, idx: wt_wr_idx};
        end
    end

    // Window buffer: store each accepted activation word at the load position.
    always_ff @(posedge clk) begin
        if (win_accept) begin
            window[wcnt] <= win_data;
        end
    end

    // Slot that will be presented next cycle, and its gathered operand pair.
    always_comb begin
        sel = '0;
        if ((state == STREAM) && (scnt != LAST_SLOT)) begin
            sel = scnt + 1'b1;
        end
        pair_idx = wmem[sel].idx;
        pair_act = '0;
        if (int'(pair_idx) < WINDOW_SIZE) begin
            pair_act = window[pair_idx];
        end
        pair_wt = wmem[sel].data;
`ifdef OPERAND_GATE_EN
        if (pair_act == '0) begin
            pair_wt = '0;
        end
`else
`endif
    end

    // Next-state and next-output logic; outputs are registered below.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        wcnt_next      = wcnt;
        scnt_next      = scnt;
        dcnt_next      = dcnt;
        act_next       = '0;
        wt_next        = '0;
        pe_rst_n_next  = 1'b1;
        win_ready_next = 1'b0;
        res_valid_next = 1'b0;
        capture        = 1'b0;
        unique case (state)
            LOAD: begin
                win_ready_next = 1'b1;
                if (win_accept) begin
                    if (wcnt == LAST_WORD) begin
                        wcnt_next      = '0;
                        state_next     = CLEAR;
                        win_ready_next = 1'b0;
                        pe_rst_n_next  = 1'b0;
                    end else begin
                        wcnt_next = wcnt + 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_next = STREAM;
                scnt_next  = '0;
                act_next   = pair_act;
                wt_next    = pair_wt;
            end
            STREAM: begin
                if (scnt == LAST_SLOT) begin
                    state_next = DRAIN;
                    scnt_next  = '0;
                    dcnt_next  = '0;
                end else begin
                    scnt_next = scnt + 1'b1;
                    act_next  = pair_act;
                    wt_next   = pair_wt;
                end
            end
            DRAIN: begin
                if (dcnt == LAST_DRAIN) begin
                    state_next     = LOAD;
                    capture        = 1'b1;
                    res_valid_next = 1'b1;
                    win_ready_next = 1'b1;
                end else begin
                    dcnt_next = dcnt + 1'b1;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // State, counters and registered outputs with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= LOAD;
            wcnt          <= '0;
            scnt          <= '0;
            dcnt          <= '0;
            win_ready     <= 1'b0;
            pe_activation <= '0;
            pe_weight     <= '0;
            pe_rst_n      <= 1'b0;
            res_valid     <= 1'b0;
            res_data      <= '0;
        end else begin
            state         <= state_next;
            wcnt          <= wcnt_next;
            scnt          <= scnt_next;
            dcnt          <= dcnt_next;
            win_ready     <= win_ready_next;
            pe_activation <= act_next;
            pe_weight     <= wt_next;
            pe_rst_n      <= pe_rst_n_next;
            res_valid     <= res_valid_next;
            if (capture) begin
                res_data <= pe_out;
            end
        end
    end

endmodule

// File: tb/tb_pe_operand_streamer.sv
// Self-checking bench for pe_operand_streamer with a behavioural PE attached.
// Build with OPERAND_GATE_EN defined to check the gated-weight variant.
module tb_pe_operand_streamer;

    localparam int NZW = 27;
    localparam int WIN = 27;
    localparam int RL  = 3;
`ifdef OPERAND_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wt_wr_en;
    logic [4:0]  wt_wr_addr;
    logic [15:0] wt_wr_data;
    logic [4:0]  wt_wr_idx;
    logic        win_valid;
    logic        win_ready;
    logic [15:0] win_data;
    logic [15:0] pe_activation;
    logic [15:0] pe_weight;
    logic        pe_rst_n;
    logic [15:0] pe_out_m;
    logic        res_valid;
    logic [15:0] res_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: kernel and window as the bench believes them to be.
    logic [15:0] m_wd  [NZW];
    logic [4:0]  m_wi  [NZW];
    logic [15:0] m_win [WIN];
    logic [15:0] last_res;

    always #5 clk = ~clk;

    pe_operand_streamer dut (
        .clk           (clk),
        .rst           (rst),
        .wt_wr_en      (wt_wr_en),
        .wt_wr_addr    (wt_wr_addr),
        .wt_wr_data    (wt_wr_data),
        .wt_wr_idx     (wt_wr_idx),
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .win_data      (win_data),
        .pe_activation (pe_activation),
        .pe_weight     (pe_weight),
        .pe_rst_n      (pe_rst_n),
        .pe_out        (pe_out_m),
        .res_valid     (res_valid),
        .res_data      (res_data)
    );

    // Q7.8 multiply, truncated back to 16 bits.
    function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p[23:8];
    endfunction

    // Behavioural PE: product register, accumulator, output register (3 cycles).
    logic [15:0] pe_prod, pe_acc;
    always @(posedge clk) begin
        if (!pe_rst_n) begin
            pe_prod  <= '0;
            pe_acc   <= '0;
            pe_out_m <= '0;
        end else begin
            pe_prod  <= qmul(pe_activation, pe_weight);
            pe_acc   <= pe_acc + pe_prod;
            pe_out_m <= pe_acc;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wr(input int s, input logic [15:0] d, input logic [4:0] ix);
        @(negedge clk);
        wt_wr_en   = 1'b1;
        wt_wr_addr = 5'(s);
        wt_wr_data = d;
        wt_wr_idx  = ix;
        m_wd[s]    = d;
        m_wi[s]    = ix;
    endtask

    task automatic wr_end();
        @(negedge clk);
        wt_wr_en = 1'b0;
    endtask

    task automatic set_kernel_uniform(input logic [15:0] w);
        for (int k = 0; k < NZW; k++) wr(k, w, 5'(k));
        wr_end();
    endtask

    task automatic load_window(input bit stall, output bit ok);
        int i = 0;
        int guard = 0;
        bit ph = 1'b1;
        while (i < WIN && guard < 500) begin
            @(negedge clk);
            guard++;
            win_valid = stall ? ph : 1'b1;
            ph = ~ph;
            win_data = m_win[i];
            if (win_valid && win_ready) i++;
        end
        ok = (i == WIN);
        check("load_complete", i, WIN);
    endtask

    // Load the model window, then follow the stream cycle by cycle.
    task automatic run_window(input bit stall, input int abort_at, input int write_at, input bit stray);
        bit ok;
        logic [4:0]  ix;
        logic [15:0] a, w, wg, acc;
        load_window(stall, ok);
        if (!ok) begin
            win_valid = 1'b0;
            return;
        end
        @(negedge clk);
        win_valid = stray;
        win_data  = 16'hDEAD;
        check("clear_pe_rst_n", pe_rst_n, 0);
        check("clear_win_ready", win_ready, 0);
        acc = '0;
        for (int k = 0; k < NZW; k++) begin
            @(negedge clk);
            wt_wr_en = 1'b0;
            ix = m_wi[k];
            a  = (int'(ix) < WIN) ? m_win[ix] : 16'h0000;
            w  = m_wd[k];
            wg = (GATE && a == 16'h0000) ? 16'h0000 : w;
            check("stream_act", pe_activation, a);
            check("stream_wt", pe_weight, wg);
            check("stream_pe_rst_n", pe_rst_n, 1);
            check("stream_win_ready", win_ready, 0);
            acc = acc + qmul(a, w);
            if (k == write_at) begin
                wt_wr_en   = 1'b1;
                wt_wr_addr = 5'(NZW - 1);
                wt_wr_data = 16'h0300;
                wt_wr_idx  = 5'(NZW - 1);
                m_wd[NZW-1] = 16'h0300;
                m_wi[NZW-1] = 5'(NZW - 1);
            end
            if (k == abort_at) begin
                rst       = 1'b0;
                win_valid = 1'b0;
                @(negedge clk);
                check("abort_win_ready", win_ready, 0);
                check("abort_act", pe_activation, 0);
                check("abort_wt", pe_weight, 0);
                check("abort_pe_rst_n", pe_rst_n, 0);
                check("abort_res_valid", res_valid, 0);
                check("abort_res_data", res_data, 0);
                rst = 1'b1;
                @(negedge clk);
                check("abort_ready_back", win_ready, 1);
                return;
            end
        end
        for (int d = 0; d < RL; d++) begin
            @(negedge clk);
            check("drain_act", pe_activation, 0);
            check("drain_wt", pe_weight, 0);
            check("drain_res_valid", res_valid, 0);
            if (d == RL - 1) win_valid = 1'b0;
        end
        @(negedge clk);
        check("res_valid_pulse", res_valid, 1);
        check("res_data_model", res_data, acc);
        check("res_win_ready", win_ready, 1);
        last_res = res_data;
        @(negedge clk);
        check("res_valid_single", res_valid, 0);
        check("res_data_hold", res_data, acc);
    endtask

    typedef struct {
        logic [15:0] wt;
        logic [15:0] act;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{wt: 16'h0100, act: 16'h0100, exp_res: 16'h1B00};
        vecs[1] = '{wt: 16'h0200, act: 16'h0080, exp_res: 16'h1B00};
        vecs[2] = '{wt: 16'hFF00, act: 16'h0100, exp_res: 16'hE500};
        vecs[3] = '{wt: 16'h0080, act: 16'h0080, exp_res: 16'h06C0};
        vecs[4] = '{wt: 16'h0000, act: 16'h1234, exp_res: 16'h0000};
        vecs[5] = '{wt: 16'h4000, act: 16'h0100, exp_res: 16'hC000};

        rst = 1'b0; win_valid = 1'b0; win_data = '0;
        wt_wr_en = 1'b0; wt_wr_addr = '0; wt_wr_data = '0; wt_wr_idx = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        check("rst_win_ready", win_ready, 0);
        check("rst_act", pe_activation, 0);
        check("rst_wt", pe_weight, 0);
        check("rst_pe_rst_n", pe_rst_n, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", win_ready, 1);

        // Uniform kernels against uniform windows.
        for (int i = 0; i < 6; i++) begin
            set_kernel_uniform(vecs[i].wt);
            for (int p = 0; p < WIN; p++) m_win[p] = vecs[i].act;
            run_window(i[0], -1, -1, 1'b0);
            check("table_res", last_res, vecs[i].exp_res);
        end

        // Sparse index: a single weight picking the last window position.
        for (int k = 0; k < NZW; k++) wr(k, (k == 0) ? 16'h0200 : 16'h0000, (k == 0) ? 5'd26 : 5'd0);
        wr_end();
        for (int p = 0; p < WIN; p++) m_win[p] = (p == 26) ? 16'h0300 : 16'h0000;
        run_window(1'b0, -1, -1, 1'b0);
        check("sparse_res", last_res, 16'h0600);

        // Out-of-range index on slot 5 contributes nothing.
        set_kernel_uniform(16'h0100);
        wr(5, 16'h0100, 5'd31);
        wr_end();
        for (int p = 0; p < WIN; p++) m_win[p] = 16'h0100;
        run_window(1'b0, -1, -1, 1'b0);
        check("oor_res", last_res, 16'h1A00);

        // Stalled load, words offered during the stream, then a clean repeat.
        set_kernel_uniform(16'h0100);
        for (int p = 0; p < WIN; p++) m_win[p] = 16'(p * 16);
        run_window(1'b1, -1, -1, 1'b1);
        check("stall_res", last_res, 16'h15F0);
        run_window(1'b0, -1, -1, 1'b0);
        check("after_stray_res", last_res, 16'h15F0);

        // Kernel write during the stream to a slot not yet streamed.
        for (int p = 0; p < WIN; p++) m_win[p] = 16'h0100;
        run_window(1'b0, -1, 3, 1'b0);
        check("midwrite_res", last_res, 16'h1D00);

        // Reset in the middle of the stream, then a full reload.
        set_kernel_uniform(16'h0100);
        run_window(1'b0, 10, -1, 1'b0);
        run_window(1'b0, -1, -1, 1'b0);
        check("post_abort_res", last_res, 16'h1B00);

        // Reset during a partial load; the reload must start at position 0.
        for (int p = 0; p < 10; p++) begin
            @(negedge clk);
            win_valid = 1'b1;
            win_data  = 16'h7F00;
        end
        @(negedge clk);
        win_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int p = 0; p < WIN; p++) m_win[p] = 16'(p * 16);
        run_window(1'b0, -1, -1, 1'b0);
        check("partial_reload_res", last_res, 16'h15F0);

        // Zero activations in the first half (gated weight when enabled).
        for (int p = 0; p < WIN; p++) m_win[p] = (p < 14) ? 16'h0000 : 16'h0100;
        run_window(1'b0, -1, -1, 1'b0);
        check("gate_res", last_res, 16'h0D00);

        // Random kernels and windows against the model.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < NZW; k++) wr(k, 16'($urandom), 5'($urandom_range(0, 31)));
            wr_end();
            for (int p = 0; p < WIN; p++) m_win[p] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            run_window(r[0], -1, -1, r[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
